// File: rtl/sine_channel_scheduler_pkg.sv
// Shared types and defaults for the time-multiplexed sine channel scheduler.
// Optional mixer output is enabled by defining SINE_SCHED_MIX_EN.
package sine_sched_pkg;

  localparam int DEF_DATA_WIDTH  = 16;
  localparam int DEF_LUT_DEPTH   = 8;
  localparam int DEF_PHASE_WIDTH = 32;
  localparam int DEF_NUM_CH      = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  // Ceiling log2, used to size the channel index (valid for value >= 2).
  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v = value - 1;
    while (v > 0) begin
      res = res + 1;
      v = v >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/sine_channel_scheduler_if.sv
// Config, LUT and sample-output bundle of the sine channel scheduler.
// Mix outputs exist only when SINE_SCHED_MIX_EN is defined.
interface sine_channel_scheduler_if
  import sine_sched_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int LUT_DEPTH   = DEF_LUT_DEPTH,
  parameter int PHASE_WIDTH = DEF_PHASE_WIDTH,
  parameter int NUM_CH      = DEF_NUM_CH
);

  localparam int CH_W = clog2(NUM_CH);

  logic                   sample_clk_ce;
  logic                   cfg_we;
  logic [CH_W-1:0]        cfg_ch;
  logic [PHASE_WIDTH-1:0] cfg_inc;
  logic                   cfg_en;
  logic [LUT_DEPTH-1:0]   lut_addr;
  logic [DATA_WIDTH-1:0]  lut_data;
  logic                   out_valid;
  logic [CH_W-1:0]        out_ch;
  logic [DATA_WIDTH-1:0]  out_sample;
  logic                   busy;
  logic                   overrun;
  logic                   overrun_clr;
`ifdef SINE_SCHED_MIX_EN
  logic                        mix_valid;
  logic [DATA_WIDTH+CH_W-1:0]  mix_sum;

  modport master (
    output sample_clk_ce, cfg_we, cfg_ch, cfg_inc, cfg_en, lut_data, overrun_clr,
    input  lut_addr, out_valid, out_ch, out_sample, busy, overrun, mix_valid, mix_sum
  );

  modport slave (
    input  sample_clk_ce, cfg_we, cfg_ch, cfg_inc, cfg_en, lut_data, overrun_clr,
    output lut_addr, out_valid, out_ch, out_sample, busy, overrun, mix_valid, mix_sum
  );
`else
  modport master (
    output sample_clk_ce, cfg_we, cfg_ch, cfg_inc, cfg_en, lut_data, overrun_clr,
    input  lut_addr, out_valid, out_ch, out_sample, busy, overrun
  );

  modport slave (
    input  sample_clk_ce, cfg_we, cfg_ch, cfg_inc, cfg_en, lut_data, overrun_clr,
    output lut_addr, out_valid, out_ch, out_sample, busy, overrun
  );
`endif

endinterface

// File: rtl/sine_ch_regfile.sv
// Shadow and active phase-increment/enable banks; shadow is written any time,
// active is loaded only at frame start so a frame never sees a half-applied config.
module sine_ch_regfile
  import sine_sched_pkg::*;
#(
  parameter  int PHASE_WIDTH = DEF_PHASE_WIDTH,
  parameter  int NUM_CH      = DEF_NUM_CH,
  localparam int CH_W        = clog2(NUM_CH)
) (
  input  logic                               clk,
  input  logic                               arst,
  input  logic                               cfg_we,
  input  logic [CH_W-1:0]                    cfg_ch,
  input  logic [PHASE_WIDTH-1:0]             cfg_inc,
  input  logic                               cfg_en,
  input  logic                               copy,
  output logic [NUM_CH-1:0][PHASE_WIDTH-1:0] act_inc,
  output logic [NUM_CH-1:0]                  act_en,
  output logic [NUM_CH-1:0]                  acc_clr
);

  logic [NUM_CH-1:0][PHASE_WIDTH-1:0] sh_inc;
  logic [NUM_CH-1:0][PHASE_WIDTH-1:0] sh_inc_nxt;
  logic [NUM_CH-1:0]                  sh_en;
  logic [NUM_CH-1:0]                  sh_en_nxt;

  // Out-of-range channel indices match no entry, so such writes are dropped.
  always_comb begin
    sh_inc_nxt = sh_inc;
    sh_en_nxt  = sh_en;
    for (int c = 0; c < NUM_CH; c++) begin
      if (cfg_we && (cfg_ch == CH_W'(c))) begin
        sh_inc_nxt[c] = cfg_inc;
        sh_en_nxt[c]  = cfg_en;
      end
    end
  end

  // Accumulator restarts unless the channel stays enabled across the copy.
  assign acc_clr = ~(act_en & sh_en_nxt);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      sh_inc  <= '0;
      sh_en   <= '0;
      act_inc <= '0;
      act_en  <= '0;
    end else begin
      sh_inc <= sh_inc_nxt;
      sh_en  <= sh_en_nxt;
      if (copy) begin
        act_inc <= sh_inc_nxt;
        act_en  <= sh_en_nxt;
      end
    end
  end

endmodule

// File: rtl/sine_channel_scheduler.sv
// Time-multiplexes one external sine LUT across NUM_CH phase accumulators.
// Define SINE_SCHED_MIX_EN to add the per-frame sample sum (mix_valid/mix_sum).
module sine_channel_scheduler
  import sine_sched_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int LUT_DEPTH   = DEF_LUT_DEPTH,
  parameter int PHASE_WIDTH = DEF_PHASE_WIDTH,
  parameter int NUM_CH      = DEF_NUM_CH
) (
  input logic                    clk,
  input logic                    arst,
  sine_channel_scheduler_if.slave bus
);

  localparam int CH_W = clog2(NUM_CH);

  state_t                             state;
  state_t                             state_nxt;
  logic [CH_W-1:0]                    slot;
  logic                               slot_last;
  logic                               copy;
  logic [NUM_CH-1:0][PHASE_WIDTH-1:0] acc;
  logic [NUM_CH-1:0][PHASE_WIDTH-1:0] act_inc;
  logic [NUM_CH-1:0]                  act_en;
  logic [NUM_CH-1:0]                  acc_clr;
  logic                               pipe_en;
  logic [CH_W-1:0]                    pipe_ch;
  logic                               pipe_last;

  sine_ch_regfile #(
    .PHASE_WIDTH(PHASE_WIDTH),
    .NUM_CH     (NUM_CH)
  ) u_regfile (
    .clk    (clk),
    .arst   (arst),
    .cfg_we (bus.cfg_we),
    .cfg_ch (bus.cfg_ch),
    .cfg_inc(bus.cfg_inc),
    .cfg_en (bus.cfg_en),
    .copy   (copy),
    .act_inc(act_inc),
    .act_en (act_en),
    .acc_clr(acc_clr)
  );

  assign slot_last = (slot == CH_W'(NUM_CH - 1));

  always_ff @(posedge clk or posedge arst) begin
    if (arst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    copy      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.sample_clk_ce) begin
          state_nxt = RUN;
          copy      = 1'b1;
        end
      end
      RUN:     if (slot_last) state_nxt = DRAIN;
      DRAIN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes that land mid-frame are dropped and flagged; a set wins over a clear.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      slot        <= '0;
      bus.busy    <= 1'b0;
      bus.overrun <= 1'b0;
    end else begin
      if (copy)              slot <= '0;
      else if (state == RUN) slot <= slot + CH_W'(1);
      bus.busy <= (state_nxt != IDLE);
      if (bus.sample_clk_ce && (state != IDLE)) bus.overrun <= 1'b1;
      else if (bus.overrun_clr)                 bus.overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      acc <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (copy && acc_clr[c])
          acc[c] <= '0;
        else if ((state == RUN) && (slot == CH_W'(c)) && act_en[c])
          acc[c] <= acc[c] + act_inc[c];
      end
    end
  end

  // Address uses the pre-increment phase; the LUT answers combinationally
  // and the sample is captured one cycle later alongside its tag.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      bus.lut_addr   <= '0;
      pipe_en        <= 1'b0;
      pipe_ch        <= '0;
      pipe_last      <= 1'b0;
      bus.out_valid  <= 1'b0;
      bus.out_ch     <= '0;
      bus.out_sample <= '0;
    end else begin
      if (state == RUN) begin
        bus.lut_addr <= acc[slot][PHASE_WIDTH-1 -: LUT_DEPTH];
        pipe_ch      <= slot;
      end
      pipe_en       <= (state == RUN) && act_en[slot];
      pipe_last     <= (state == RUN) && slot_last;
      bus.out_valid <= pipe_en;
      if (pipe_en) begin
        bus.out_sample <= bus.lut_data;
        bus.out_ch     <= pipe_ch;
      end
    end
  end

`ifdef SINE_SCHED_MIX_EN
  localparam int MIX_W = DATA_WIDTH + CH_W;

  logic [MIX_W-1:0] mix_run;
  logic [MIX_W-1:0] mix_add;

  assign mix_add = pipe_en ? {{CH_W{1'b0}}, bus.lut_data} : '0;

  // NUM_CH full-scale samples fit in DATA_WIDTH+CH_W bits, so no overflow.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      mix_run       <= '0;
      bus.mix_valid <= 1'b0;
      bus.mix_sum   <= '0;
    end else begin
      if (copy) mix_run <= '0;
      else      mix_run <= mix_run + mix_add;
      bus.mix_valid <= pipe_last;
      if (pipe_last) bus.mix_sum <= mix_run + mix_add;
    end
  end
`endif

endmodule
